// File: rtl/display_arbiter.sv
// display_arbiter: shares the 4-digit seven-segment display between producer A
// (keypad echo) and producer B (calculator result). Each accepted word stays on
// screen for at least HOLD_TICKS cycles before it can be replaced. Simultaneous
// requests are granted round-robin, and A wins the first tie.
// Optional build macro: DISP_BLINK_EN blinks a stale (FREE-state) value by
// toggling n between its stored value and 0 every BLINK_TICKS cycles.
module display_arbiter #(
    parameter int HOLD_TICKS  = 25000000,
    parameter int BLINK_TICKS = 6250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_data,
    input  logic [2:0]  a_len,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_data,
    input  logic [2:0]  b_len,
    input  logic        clear,
    output logic [3:0]  n,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  num4,
    output logic        owner,
    output logic        busy
);

    localparam int CW = $clog2(HOLD_TICKS) + 1;

    typedef enum logic [1:0] {IDLE, HOLD, FREE} state_t;

    state_t          state;
    logic [CW-1:0]   hcnt;
    logic            last_owner;
    logic [3:0]      n_q;
    logic [3:0][3:0] digits;      // [3] = leftmost digit

    logic            accept_ok;
    logic            xfer;
    logic [15:0]     sel_data;
    logic [2:0]      sel_len;
    logic [3:0]      sel_n;

    // Grant is purely combinational; clear and reset both suppress it so that
    // no word is consumed on a cycle where it could not be displayed.
    assign accept_ok = (state == IDLE || state == FREE) && !clear && !reset;
    assign a_ready   = accept_ok & a_valid & (!b_valid | last_owner);
    assign b_ready   = accept_ok & b_valid & (!a_valid | !last_owner);
    assign xfer      = a_ready | b_ready;

    assign sel_data  = b_ready ? b_data : a_data;
    assign sel_len   = b_ready ? b_len  : a_len;
    assign sel_n     = (sel_len > 3'd4) ? 4'd4 : {1'b0, sel_len};

    assign num1 = digits[3];
    assign num2 = digits[2];
    assign num3 = digits[1];
    assign num4 = digits[0];

    // Main FSM: latch accepted word, run the hold countdown, release to FREE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            n_q        <= '0;
            digits     <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            busy       <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            hcnt   <= '0;
            n_q    <= '0;
            digits <= '0;
            busy   <= 1'b0;
        end else if (xfer) begin
            state      <= HOLD;
            hcnt       <= CW'(HOLD_TICKS - 1);
            n_q        <= sel_n;
            digits     <= sel_data;
            owner      <= b_ready;
            last_owner <= b_ready;
            busy       <= 1'b1;
        end else if (state == HOLD) begin
            if (hcnt == '0) begin
                state <= FREE;
                busy  <= 1'b0;
            end else begin
                hcnt <= hcnt - 1'b1;
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS) + 1;

    logic [BW-1:0] bcnt;
    logic          blank;

    // Blink phase generator; held at a visible phase outside FREE so every
    // entry to FREE starts with the value shown.
    always_ff @(posedge clk) begin
        if (reset || state != FREE) begin
            bcnt  <= '0;
            blank <= 1'b0;
        end else if (bcnt == BW'(BLINK_TICKS - 1)) begin
            bcnt  <= '0;
            blank <= ~blank;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign n = (state == FREE && blank) ? 4'd0 : n_q;
`else
    assign n = n_q;
`endif

endmodule
